// File: rtl/if_id_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_buffer_if : fetch-side and decode-side signals of the IF/ID buffer   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface if_id_buffer_if #(
  parameter int DEPTH = 2,
  parameter int PCW   = 16
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [PCW-1:0]   in_pc;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [15:0]      out_instr;
  logic [PCW-1:0]   out_pc;
  logic [4:0]       opcode;
  logic [1:0]       op_ext;
  logic             halted;
  logic [CNTW-1:0]  count;

  // Environment view: fetch and decode stages around the buffer.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, opcode, op_ext, halted, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, opcode, op_ext, halted, count
  );
endinterface

`default_nettype wire

// File: rtl/if_id_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_buffer : small instruction FIFO between fetch and decode, with       |
// | flush and HALT drain/stop handling.        Revision 1.0                    |
// +----------------------------------------------------------------------------+
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter int          PCW       = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic           clk,
  input  logic           rst_n,
  if_id_buffer_if.slave  bus
);
  localparam int              PTRW      = $clog2(DEPTH);
  localparam int              CNTW      = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] C_DEPTH   = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] C_ONE     = CNTW'(1);
  localparam logic [PTRW-1:0] C_PTR_ONE = PTRW'(1);
  localparam logic [4:0]      C_HALT_OP = 5'b00000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     instr_q [DEPTH];
  logic [15:0]     instr_d [DEPTH];
  logic [PCW-1:0]  pc_q    [DEPTH];
  logic [PCW-1:0]  pc_d    [DEPTH];
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [15:0]     w_out_instr;

  // in_ready deliberately ignores out_ready: a full buffer never accepts.
  assign w_in_ready  = (state_q == ST_RUN) && (count_q < C_DEPTH);
  assign w_out_valid = (state_q != ST_HALTED) && (count_q != '0);
  assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = instr_q;
    pc_d     = pc_q;

    if (state_q == ST_HALTED) begin
      count_d = '0;
    end else if (bus.flush) begin
      // A HALT waiting in DRAIN was on the squashed path, so go back to RUN.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      state_d  = ST_RUN;
    end else begin
      if (w_push) begin
        instr_d[wr_ptr_q] = bus.in_instr;
        pc_d[wr_ptr_q]    = bus.in_pc;
        wr_ptr_d          = wr_ptr_q + C_PTR_ONE;
        if (bus.in_instr[15:11] == C_HALT_OP) begin
          state_d = ST_DRAIN;
        end
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + C_ONE;
      end else if (!w_push && w_pop) begin
        count_d = count_q - C_ONE;
      end
      // Nothing is accepted after the HALT, so it is always the last entry.
      if ((state_q == ST_DRAIN) && w_pop && (count_q == C_ONE)) begin
        state_d = ST_HALTED;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
    end
  end

  assign w_out_instr   = w_out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_instr;
  assign bus.out_pc    = w_out_valid ? pc_q[rd_ptr_q] : '0;
  assign bus.opcode    = w_out_instr[15:11];
  assign bus.op_ext    = w_out_instr[1:0];
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.count     = count_q;
endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_id_buffer : randomized and directed bench for if_id_buffer against   |
// | a queue-based reference model.             Revision 1.0                    |
// +----------------------------------------------------------------------------+
module tb_if_id_buffer;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  if_id_buffer_if #(.DEPTH(DEPTH), .PCW(16)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .PCW(16), .NOP_INSTR(16'h0800)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of entries plus the high-level mode.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;
  typedef enum {M_RUN, M_DRAIN, M_HALTED} mode_t;

  ent_t  mq[$];
  mode_t mode;

  function automatic void model_reset();
    mq.delete();
    mode = M_RUN;
  endfunction

  function automatic void model_edge();
    ent_t  e;
    logic  rdy, vld, push, pop;
    rdy  = (mode == M_RUN) && (mq.size() < DEPTH);
    vld  = (mode != M_HALTED) && (mq.size() > 0);
    push = bus.in_valid && rdy && !bus.flush;
    pop  = vld && bus.out_ready && !bus.flush;
    if (mode == M_HALTED) return;
    if (bus.flush) begin
      mq.delete();
      mode = M_RUN;
      return;
    end
    if (pop) begin
      e = mq.pop_front();
      if (e.instr[15:11] == 5'd0) begin
        mode = M_HALTED;
        mq.delete();
      end
    end
    if (push) begin
      mq.push_back('{instr: bus.in_instr, pc: bus.in_pc});
      if (bus.in_instr[15:11] == 5'd0) mode = M_DRAIN;
    end
  endfunction

  // {valid, instr, pc, count, in_ready, halted, opcode, op_ext}
  function automatic logic [43:0] exp_vec();
    logic        v;
    logic [15:0] ins, pc;
    v   = (mode != M_HALTED) && (mq.size() > 0);
    ins = v ? mq[0].instr : 16'h0800;
    pc  = v ? mq[0].pc : 16'h0000;
    return {v, ins, pc, 2'(mq.size()), (mode == M_RUN) && (mq.size() < DEPTH),
            mode == M_HALTED, ins[15:11], ins[1:0]};
  endfunction

  function automatic logic [43:0] dut_vec();
    return {bus.out_valid, bus.out_instr, bus.out_pc, bus.count, bus.in_ready,
            bus.halted, bus.opcode, bus.op_ext};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'd0) w[11] = 1'b1;
    return w;
  endfunction

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.flush     = fl;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 0; bus.out_ready = 0;
    pulse_reset();
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.opcode !== 5'b00001 || bus.count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_idle got rdy=%b op=%b cnt=%0d exp rdy=1 op=00001 cnt=0",
               bus.in_ready, bus.opcode, bus.count);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 16'h0, 16'h0, 0, 1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    step(1, 16'h4803, 16'h0010, 0, 1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.opcode !== 5'b01001 || bus.op_ext !== 2'b11 ||
        bus.out_pc !== 16'h0010) begin
      miscompares++;
      $display("FAIL single_head got v=%b op=%b ext=%b pc=%h exp v=1 op=01001 ext=11 pc=0010",
               bus.out_valid, bus.opcode, bus.op_ext, bus.out_pc);
    end
    step(0, 16'h0, 16'h0, 0, 1);
    vectors++;
    if (dut_vec() !== exp_vec() || bus.count !== 2'd0) begin
      miscompares++;
      $display("FAIL single_pop got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_stall_full();
    logic [15:0] ins [3];
    for (int i = 0; i < 3; i++) ins[i] = rand_instr();
    for (int i = 0; i < 3; i++) begin
      step(1, ins[i], 16'(16'h0100 + i), 0, 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_push%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_instr !== ins[0]) begin
      miscompares++;
      $display("FAIL stall_full got rdy=%b head=%h exp rdy=0 head=%h",
               bus.in_ready, bus.out_instr, ins[0]);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 16'h0, 16'h0, 0, 1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_drain%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      step(i < 10, rand_instr(), 16'($urandom), 0, 1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    step(1, rand_instr(), 16'h0200, 0, 0);
    step(1, rand_instr(), 16'h0202, 0, 0);
    step(1, 16'h6123, 16'h0204, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_full got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, 16'h6124, 16'h0206, 0, 0);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL flush_after got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(0, 16'h0, 16'h0, 0, 1);
  endtask

  task automatic test_halt();
    step(1, 16'h5800, 16'h0300, 0, 0);
    step(1, 16'h0000, 16'h0302, 0, 0);
    vectors++;
    if (bus.in_ready !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL halt_drain got=%h exp=%h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      step(1, rand_instr(), 16'h0400, 0, 1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_pop%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_stop got halted=%b v=%b exp halted=1 v=0", bus.halted, bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, rand_instr(), 16'h0500, i[0], 1);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_frozen%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    pulse_reset();
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL halt_reset got=%h exp=%h", dut_vec(), exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_drain_flush();
    step(1, 16'h5800, 16'h0600, 0, 0);
    step(1, 16'h0003, 16'h0602, 0, 0);
    step(1, 16'h7777, 16'h0604, 1, 0);
    vectors++;
    if (dut_vec() !== exp_vec() || bus.in_ready !== 1'b1 || bus.halted !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_flush got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, 16'h7778, 16'h0606, 0, 1);
    step(0, 16'h0, 16'h0, 0, 1);
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL drain_flush_run got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = ($urandom_range(0, 15) == 0) ? 16'($urandom & 32'h07FF) : rand_instr();
      step($urandom_range(0, 3) != 0, ins, 16'($urandom),
           $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (mode == M_HALTED && $urandom_range(0, 2) == 0) begin
        pulse_reset();
        vectors++;
        if (dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL random_reset_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
        end
        @(negedge clk) rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_stall_full();
    test_back_to_back();
    test_flush();
    test_halt();
    test_drain_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
